// File: rtl/pipe_hazard_unit_if.sv
// ID-stage request/response bundle for the hazard and forwarding controller.
// The master side is the decode stage; the slave side is pipe_hazard_unit.
interface pipe_hazard_unit_if #(
  parameter int REG_AW = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  // Decode-stage request
  logic              id_valid;
  logic              id_rs_en;
  logic [REG_AW-1:0] id_rs_addr;
  logic              id_rt_en;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_addr;
  logic [SEL_W-1:0]  id_ready_stg;
  logic              flush;

  // Hazard decisions back to decode
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs;
  logic [SEL_W-1:0]  fwd_rt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              busy;

  modport master (
    output id_valid, id_rs_en, id_rs_addr, id_rt_en, id_rt_addr,
           id_wr_en, id_wr_addr, id_ready_stg, flush,
    input  stall, fwd_rs, fwd_rt, stall_cnt, busy
  );

  modport slave (
    input  id_valid, id_rs_en, id_rs_addr, id_rt_en, id_rt_addr,
           id_wr_en, id_wr_addr, id_ready_stg, flush,
    output stall, fwd_rs, fwd_rt, stall_cnt, busy
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// RAW hazard / forwarding controller: shift-register model of the EX..WB
// writers, per-entry result-ready stage, stall/forward decisions for ID.
module pipe_hazard_unit #(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_unit_if.slave bus
);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] addr;
    logic [SEL_W-1:0]  rdy;
  } entry_t;

  typedef struct packed {
    logic             hit;
    logic             haz;
    logic [SEL_W-1:0] sel;
  } match_t;

  entry_t           trk [DEPTH];
  entry_t           ent0_next;
  match_t           rs_m;
  match_t           rt_m;
  logic             stall_int;
  logic             busy_int;
  logic [CNT_W-1:0] cnt_q;

  // A source matches an entry only if that entry is a live register writer.
  function automatic logic src_match(input entry_t e, input logic en,
                                     input logic [REG_AW-1:0] src);
    logic zero_src;
    zero_src  = (ZERO_REG != 0) && (src == '0);
    return en && e.v && e.wr && (e.addr == src) && !zero_src;
  endfunction

  // Walk oldest to youngest so the lowest-index (youngest) writer wins.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rs_m = '0;
    rt_m = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_match(trk[k], bus.id_rs_en, bus.id_rs_addr)) begin
        rs_m.hit = 1'b1;
        rs_m.haz = SEL_W'(k) < trk[k].rdy;
        rs_m.sel = SEL_W'(k + 1);
      end
      if (src_match(trk[k], bus.id_rt_en, bus.id_rt_addr)) begin
        rt_m.hit = 1'b1;
        rt_m.haz = SEL_W'(k) < trk[k].rdy;
        rt_m.sel = SEL_W'(k + 1);
      end
    end
  end

  // Flush outranks stall: a squashed ID slot never waits on anything.
  assign stall_int = bus.id_valid && !bus.flush && (rs_m.haz || rt_m.haz);

  always_comb begin
    ent0_next = '0;
    if (bus.id_valid && !stall_int && !bus.flush) begin
      ent0_next.v    = 1'b1;
      ent0_next.wr   = bus.id_wr_en;
      ent0_next.addr = bus.id_wr_addr;
      ent0_next.rdy  = bus.id_ready_stg;
    end
  end

  always_comb begin
    busy_int = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      busy_int = busy_int | (trk[k].v & trk[k].wr);
    end
  end

  // Entry DEPTH-1 retires into the RF, which is read back in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the tracker is a handful of flops, not a RAM, so clearing it on reset is cheap.
      for (int k = 0; k < DEPTH; k++) begin
        trk[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      trk[0] <= ent0_next;
      for (int k = 1; k < DEPTH; k++) begin
        trk[k] <= trk[k-1];
      end
      if (stall_int && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall     = stall_int;
  assign bus.fwd_rs    = (!stall_int && rs_m.hit && !rs_m.haz) ? rs_m.sel : '0;
  assign bus.fwd_rt    = (!stall_int && rt_m.hit && !rt_m.haz) ? rt_m.sel : '0;
  assign bus.stall_cnt = cnt_q;
  assign bus.busy      = busy_int;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: a default instance plus a 4-bit
// counter instance sharing the same stimulus for saturation checks.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.REG_AW(4), .SEL_W(2), .CNT_W(16)) bus   ();
  pipe_hazard_unit_if #(.REG_AW(4), .SEL_W(2), .CNT_W(4))  bus_s ();

  assign bus_s.id_valid     = bus.id_valid;
  assign bus_s.id_rs_en     = bus.id_rs_en;
  assign bus_s.id_rs_addr   = bus.id_rs_addr;
  assign bus_s.id_rt_en     = bus.id_rt_en;
  assign bus_s.id_rt_addr   = bus.id_rt_addr;
  assign bus_s.id_wr_en     = bus.id_wr_en;
  assign bus_s.id_wr_addr   = bus.id_wr_addr;
  assign bus_s.id_ready_stg = bus.id_ready_stg;
  assign bus_s.flush        = bus.flush;

  pipe_hazard_unit #(.DEPTH(3), .REG_AW(4), .ZERO_REG(1), .SEL_W(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_hazard_unit #(.DEPTH(3), .REG_AW(4), .ZERO_REG(1), .SEL_W(2), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic rs_en, input logic [3:0] rs,
                       input logic rt_en, input logic [3:0] rt, input logic wr_en,
                       input logic [3:0] wr, input logic [1:0] rdy);
    bus.id_valid     = v;
    bus.id_rs_en     = rs_en;
    bus.id_rs_addr   = rs;
    bus.id_rt_en     = rt_en;
    bus.id_rt_addr   = rt;
    bus.id_wr_en     = wr_en;
    bus.id_wr_addr   = wr;
    bus.id_ready_stg = rdy;
    bus.flush        = 1'b0;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0);
  endtask

  task automatic writer(input logic [3:0] dst, input logic [1:0] rdy);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, dst, rdy);
  endtask

  task automatic reader(input logic rs_en, input logic [3:0] rs,
                        input logic rt_en, input logic [3:0] rt);
    drive(1'b1, rs_en, rs, rt_en, rt, 1'b0, 4'd0, 2'd0);
  endtask

  initial begin
    // Reset held low with random inputs toggling
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'($urandom), 1'b1, 4'($urandom), 1'b1, 4'($urandom),
            2'($urandom_range(0, 1)));
      bus.flush = 1'($urandom);
      at_neg();
      #1;
    end
    bus.flush = 1'b0;
    at_neg();
    chk("rst_stall",   32'(bus.stall),     32'd0);
    chk("rst_fwd_rs",  32'(bus.fwd_rs),    32'd0);
    chk("rst_fwd_rt",  32'(bus.fwd_rt),    32'd0);
    chk("rst_busy",    32'(bus.busy),      32'd0);
    chk("rst_cnt",     32'(bus.stall_cnt), 32'd0);
    tick();

    // Release and issue ADD r1: busy for exactly DEPTH cycles
    rst = 1'b1;
    writer(4'd1, 2'd0);
    at_neg();
    chk("busy_pre", 32'(bus.busy), 32'd0);
    tick();
    bubble();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("busy_c%0d", i), 32'(bus.busy), 32'd1);
      tick();
    end
    at_neg();
    chk("busy_done", 32'(bus.busy), 32'd0);
    tick();

    // ALU chain with 0..3 gaps
    for (int gap = 0; gap < 4; gap++) begin
      writer(4'd3, 2'd0);
      tick();
      for (int g = 0; g < gap; g++) begin
        bubble();
        tick();
      end
      reader(1'b1, 4'd3, 1'b0, 4'd0);
      at_neg();
      chk($sformatf("alu_gap%0d_stall", gap), 32'(bus.stall), 32'd0);
      chk($sformatf("alu_gap%0d_fwd", gap), 32'(bus.fwd_rs), (gap < 3) ? 32'(gap + 1) : 32'd0);
      tick();
    end

    // Load-use on rt: one stall then forward from stage 1 output
    writer(4'd5, 2'd1);
    tick();
    reader(1'b0, 4'd0, 1'b1, 4'd5);
    at_neg();
    chk("lu_stall",  32'(bus.stall),  32'd1);
    chk("lu_fwd0",   32'(bus.fwd_rt), 32'd0);
    tick();
    at_neg();
    chk("lu_stall2", 32'(bus.stall),     32'd0);
    chk("lu_fwd_rt", 32'(bus.fwd_rt),    32'd2);
    chk("lu_cnt",    32'(bus.stall_cnt), 32'd1);
    tick();

    // WAW: ADD r2 then LW r2, reader sees the load
    writer(4'd2, 2'd0);
    tick();
    writer(4'd2, 2'd1);
    tick();
    reader(1'b1, 4'd2, 1'b0, 4'd0);
    at_neg();
    chk("waw_stall", 32'(bus.stall), 32'd1);
    tick();
    at_neg();
    chk("waw_stall2", 32'(bus.stall),     32'd0);
    chk("waw_fwd",    32'(bus.fwd_rs),    32'd2);
    chk("waw_cnt",    32'(bus.stall_cnt), 32'd2);
    tick();

    // Flush during load-use stall; the flushed writer of r7 must not enter
    writer(4'd6, 2'd1);
    tick();
    drive(1'b1, 1'b1, 4'd6, 1'b0, 4'd0, 1'b1, 4'd7, 2'd0);
    at_neg();
    chk("fl_pre_stall", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("fl_stall", 32'(bus.stall), 32'd0);
    tick();
    reader(1'b1, 4'd6, 1'b1, 4'd7);
    at_neg();
    chk("fl_stall_after", 32'(bus.stall),     32'd0);
    chk("fl_fwd_rs",      32'(bus.fwd_rs),    32'd2);
    chk("fl_bubble_rt",   32'(bus.fwd_rt),    32'd0);
    chk("fl_cnt",         32'(bus.stall_cnt), 32'd2);
    tick();

    // Register 0 is never a hazard or forward source
    writer(4'd0, 2'd1);
    tick();
    reader(1'b1, 4'd0, 1'b1, 4'd0);
    at_neg();
    chk("r0_stall",  32'(bus.stall),  32'd0);
    chk("r0_fwd_rs", 32'(bus.fwd_rs), 32'd0);
    chk("r0_fwd_rt", 32'(bus.fwd_rt), 32'd0);
    tick();

    // Illegal ready stage 3: stalls until retirement, then reads RF
    writer(4'd8, 2'd3);
    tick();
    reader(1'b1, 4'd8, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("ill_stall%0d", i), 32'(bus.stall), 32'd1);
      tick();
    end
    at_neg();
    chk("ill_free",   32'(bus.stall),     32'd0);
    chk("ill_fwd",    32'(bus.fwd_rs),    32'd0);
    chk("ill_cnt",    32'(bus.stall_cnt), 32'd5);
    chk("ill_cnt_s",  32'(bus_s.stall_cnt), 32'd5);
    tick();

    // Saturation: 21 more stalls (4-bit counter pins at 15)
    for (int it = 0; it < 7; it++) begin
      writer(4'd9, 2'd3);
      tick();
      reader(1'b1, 4'd9, 1'b0, 4'd0);
      tick();
      tick();
      tick();
    end
    at_neg();
    chk("sat_cnt_s", 32'(bus_s.stall_cnt), 32'd15);
    chk("sat_cnt",   32'(bus.stall_cnt),   32'd26);
    tick();
    writer(4'd9, 2'd3);
    tick();
    reader(1'b1, 4'd9, 1'b0, 4'd0);
    tick();
    at_neg();
    chk("sat_hold_stall", 32'(bus.stall),       32'd1);
    chk("sat_hold_s",     32'(bus_s.stall_cnt), 32'd15);
    chk("sat_hold",       32'(bus.stall_cnt),   32'd27);

    // Reset mid-stall clears everything immediately
    rst = 1'b0;
    #1;
    chk("mrst_stall", 32'(bus.stall),       32'd0);
    chk("mrst_busy",  32'(bus.busy),        32'd0);
    chk("mrst_cnt",   32'(bus.stall_cnt),   32'd0);
    chk("mrst_cnt_s", 32'(bus_s.stall_cnt), 32'd0);
    tick();
    rst = 1'b1;
    at_neg();
    chk("post_rst_stall", 32'(bus.stall),  32'd0);
    chk("post_rst_fwd",   32'(bus.fwd_rs), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
